// File: rtl/modulation_pkg.sv
//------------------------------------------------------------------------------
// Package    : modulation_pkg
// Description: Shared types and defaults for the multichannel square-wave
//              modulator.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package modulation_pkg;

    localparam int PERIOD_W_DEF = 8;
    localparam int HALF_PERIOD_RST_DEF = 3;

    typedef logic [PERIOD_W_DEF-1:0] half_period_t;

    // Channel state at the default counter width
    typedef struct packed {
        half_period_t cnt;
        half_period_t active;
        half_period_t shadow;
        logic         pending;
        logic         out;
    } chan_state_t;

endpackage

`default_nettype wire

// File: rtl/mod_channel.sv
//------------------------------------------------------------------------------
// Module     : mod_channel
// Description: One modulation channel: tick counter, shadowed half-period with
//              commit at full-period boundaries, envelope output.
//              Optional macro MOD_PHASE_OFFSET_EN adds a resync phase offset.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_channel
    import modulation_pkg::*;
#(
    parameter int PERIOD_W        = PERIOD_W_DEF,
    parameter int HALF_PERIOD_RST = HALF_PERIOD_RST_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                enable,
    input  logic                resync,
    input  logic                cfg_wr,
    input  logic [PERIOD_W-1:0] cfg_half_period,
`ifdef MOD_PHASE_OFFSET_EN
    input  logic                cfg_phase_wr,
    input  logic [PERIOD_W-1:0] cfg_phase,
`endif
    output logic                mod_out,
    output logic                period_start
);

    localparam logic [PERIOD_W-1:0] c_hp_rst = PERIOD_W'(HALF_PERIOD_RST);

    typedef struct packed {
        logic [PERIOD_W-1:0] cnt;
        logic [PERIOD_W-1:0] active;
        logic [PERIOD_W-1:0] shadow;
        logic                pending;
        logic                out;
    } state_t;

    state_t              st_q, st_d;
    logic                period_start_q, period_start_d;
    logic [PERIOD_W-1:0] w_resync_cnt;

`ifdef MOD_PHASE_OFFSET_EN
    logic [PERIOD_W-1:0] offset_q, offset_d;
    logic [PERIOD_W-1:0] w_resync_hp;

    // An offset that does not fit the half-period in force after resync is dropped
    assign w_resync_hp  = st_q.pending ? st_q.shadow : st_q.active;
    assign w_resync_cnt = (offset_q < w_resync_hp) ? offset_q : '0;

    always_comb begin
        offset_d = offset_q;
        if (cfg_phase_wr) offset_d = cfg_phase;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) offset_q <= '0;
        else        offset_q <= offset_d;
    end
`else
    assign w_resync_cnt = '0;
`endif

    always_comb begin
        st_d           = st_q;
        period_start_d = 1'b0;

        if (resync) begin
            st_d.cnt = w_resync_cnt;
            st_d.out = 1'b1;
            if (st_q.pending) begin
                st_d.active  = st_q.shadow;
                st_d.pending = 1'b0;
            end
        end else if (st_q.active == '0) begin
            st_d.cnt = '0;
            st_d.out = 1'b1;
        end else if (tick && enable) begin
            if (st_q.cnt == st_q.active - PERIOD_W'(1)) begin
                st_d.cnt = '0;
                st_d.out = ~st_q.out;
                // Rising edge closes a full period: the only glitch-free commit point
                if (!st_q.out) begin
                    period_start_d = 1'b1;
                    if (st_q.pending) begin
                        st_d.active  = st_q.shadow;
                        st_d.pending = 1'b0;
                    end
                end
            end else begin
                st_d.cnt = st_q.cnt + PERIOD_W'(1);
            end
        end

        // Writes land after any commit above, so a commit always sees the old shadow
        if (cfg_wr) begin
            if (!enable || st_q.active == '0) begin
                st_d.active    = cfg_half_period;
                st_d.shadow    = cfg_half_period;
                st_d.cnt       = '0;
                st_d.out       = 1'b1;
                st_d.pending   = 1'b0;
                period_start_d = 1'b0;
            end else begin
                st_d.shadow  = cfg_half_period;
                st_d.pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q.cnt       <= '0;
            st_q.active    <= c_hp_rst;
            st_q.shadow    <= c_hp_rst;
            st_q.pending   <= 1'b0;
            st_q.out       <= 1'b1;
            period_start_q <= 1'b0;
        end else begin
            st_q           <= st_d;
            period_start_q <= period_start_d;
        end
    end

    assign mod_out      = st_q.out;
    assign period_start = period_start_q;

endmodule

`default_nettype wire

// File: rtl/multichannel_modulation.sv
//------------------------------------------------------------------------------
// Module     : multichannel_modulation
// Description: NUM_CH independent square-wave envelopes clocked by rising edges
//              of sync. Optional macro MOD_PHASE_OFFSET_EN adds phase offsets.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multichannel_modulation
    import modulation_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int PERIOD_W        = PERIOD_W_DEF,
    parameter int HALF_PERIOD_RST = HALF_PERIOD_RST_DEF,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic [NUM_CH-1:0]   mod_enable,
    input  logic                resync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_half_period,
`ifdef MOD_PHASE_OFFSET_EN
    input  logic                cfg_phase_we,
    input  logic [PERIOD_W-1:0] cfg_phase,
`endif
    output logic [NUM_CH-1:0]   mod_out,
    output logic [NUM_CH-1:0]   period_start
);

    logic sync_q, sync_d;
    logic w_tick;

    always_comb sync_d = sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 1'b0;
        else        sync_q <= sync_d;
    end

    assign w_tick = sync & ~sync_q;

    // Out-of-range channel numbers match no instance and are dropped
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_sel;
        assign w_sel = (cfg_ch == CH_W'(i));

        mod_channel #(
            .PERIOD_W        (PERIOD_W),
            .HALF_PERIOD_RST (HALF_PERIOD_RST)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .tick            (w_tick),
            .enable          (mod_enable[i]),
            .resync          (resync),
            .cfg_wr          (cfg_we & w_sel),
            .cfg_half_period (cfg_half_period),
`ifdef MOD_PHASE_OFFSET_EN
            .cfg_phase_wr    (cfg_phase_we & w_sel),
            .cfg_phase       (cfg_phase),
`endif
            .mod_out         (mod_out[i]),
            .period_start    (period_start[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_multichannel_modulation.sv
//------------------------------------------------------------------------------
// Module     : tb_multichannel_modulation
// Description: Directed self-checking bench for multichannel_modulation
//              (3 channels so cfg_ch=3 is an out-of-range address).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multichannel_modulation;

    localparam int NUM_CH = 3;
    localparam int PW     = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sync;
    logic [NUM_CH-1:0] mod_enable;
    logic              resync;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [PW-1:0]     cfg_half_period;
`ifdef MOD_PHASE_OFFSET_EN
    logic              cfg_phase_we;
    logic [PW-1:0]     cfg_phase;
`endif
    logic [NUM_CH-1:0] mod_out;
    logic [NUM_CH-1:0] period_start;

    int n_total = 0;
    int n_pass  = 0;
    int ps_cnt [NUM_CH];
    logic ps_clr = 1'b0;

    multichannel_modulation #(
        .NUM_CH          (NUM_CH),
        .PERIOD_W        (PW),
        .HALF_PERIOD_RST (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sync            (sync),
        .mod_enable      (mod_enable),
        .resync          (resync),
        .cfg_we          (cfg_we),
        .cfg_ch          (cfg_ch),
        .cfg_half_period (cfg_half_period),
`ifdef MOD_PHASE_OFFSET_EN
        .cfg_phase_we    (cfg_phase_we),
        .cfg_phase       (cfg_phase),
`endif
        .mod_out         (mod_out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (ps_clr)               ps_cnt[i] <= 0;
            else if (period_start[i]) ps_cnt[i] <= ps_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sync tick spans 4 clk; returns at a negedge after the tick took effect
    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) sync = 1'b1;
            @(negedge clk);
            @(negedge clk) sync = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [PW-1:0] hp);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_half_period = hp;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_resync();
        @(negedge clk) resync = 1'b1;
        @(negedge clk) resync = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_ps();
        @(negedge clk) ps_clr = 1'b1;
        @(negedge clk) ps_clr = 1'b0;
    endtask

`ifdef MOD_PHASE_OFFSET_EN
    task automatic phase_write(input logic [1:0] ch, input logic [PW-1:0] ph);
        @(negedge clk);
        cfg_phase_we = 1'b1; cfg_ch = ch; cfg_phase = ph;
        @(negedge clk);
        cfg_phase_we = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; sync = 1'b0; mod_enable = 3'b111; resync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_half_period = '0;
`ifdef MOD_PHASE_OFFSET_EN
        cfg_phase_we = 1'b0; cfg_phase = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) ps_cnt[i] = 0;

        repeat (3) @(negedge clk);
        check("reset_mod_out", 8'(mod_out), 8'h07);
        check("reset_period_start", 8'(period_start), 8'h00);
        rst_n = 1'b1;
        clear_ps();

        // hp=3 everywhere: high for 3 ticks, low for 3 ticks
        ticks(2); check("t2_high", 8'(mod_out), 8'h07);
        ticks(1); check("t3_fall", 8'(mod_out), 8'h00);
        ticks(3); check("t6_rise", 8'(mod_out), 8'h07);
        @(negedge clk);
        check("t6_ps_ch0", 8'(ps_cnt[0]), 8'd1);
        check("t6_ps_ch1", 8'(ps_cnt[1]), 8'd1);
        check("t6_ps_ch2", 8'(ps_cnt[2]), 8'd1);

        // ch1 gets hp=6 mid-high-phase; it commits at the t12 rise
        ticks(1);
        cfg_write(2'd1, 8'd6);
        ticks(2); check("t9", 8'(mod_out), 8'h00);
        ticks(3); check("t12", 8'(mod_out), 8'h07);
        ticks(3); check("t15", 8'(mod_out), 8'h02);
        ticks(3); check("t18", 8'(mod_out), 8'h05);
        ticks(3); check("t21", 8'(mod_out), 8'h00);
        ticks(3); check("t24", 8'(mod_out), 8'h07);

        // Freeze ch2 low with cnt=1 for 5 ticks, then resume
        ticks(4);
        mod_enable = 3'b011;
        ticks(5); check("t33_frozen", 8'(mod_out), 8'h00);
        mod_enable = 3'b111;
        ticks(1); check("t34_resume", 8'(mod_out), 8'h00);
        ticks(1); check("t35_resume", 8'(mod_out), 8'h04);

        // ch0 low at cnt=2 with hp=4 pending, then resync
        cfg_write(2'd0, 8'd4);
        clear_ps();
        pulse_resync();
        check("resync_out", 8'(mod_out), 8'h07);
        check("resync_ps_ch0", 8'(ps_cnt[0]), 8'd0);
        check("resync_ps_ch1", 8'(ps_cnt[1]), 8'd0);
        ticks(3); check("r3", 8'(mod_out), 8'h03);
        ticks(1); check("r4", 8'(mod_out), 8'h02);
        ticks(2); check("r6", 8'(mod_out), 8'h04);

        // hp=0 written to disabled ch2, then enabled
        mod_enable = 3'b011;
        cfg_write(2'd2, 8'd0);
        check("hp0_write", 8'(mod_out), 8'h04);
        mod_enable = 3'b111;
        clear_ps();
        ticks(4); check("r10", 8'(mod_out), 8'h05);
        check("hp0_ps_ch2", 8'(ps_cnt[2]), 8'd0);
        check("r8_ps_ch0", 8'(ps_cnt[0]), 8'd1);
        cfg_write(2'd3, 8'd1);
        ticks(2); check("r12_bad_addr", 8'(mod_out), 8'h06);
        check("r12_ps_ch1", 8'(ps_cnt[1]), 8'd1);
        check("r12_ps_ch2", 8'(ps_cnt[2]), 8'd0);

        // Reset mid-operation restores hp=3 on every channel
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("rst2_mod_out", 8'(mod_out), 8'h07);
        check("rst2_period_start", 8'(period_start), 8'h00);
        rst_n = 1'b1;
        ticks(2); check("rst2_t2", 8'(mod_out), 8'h07);
        ticks(1); check("rst2_t3", 8'(mod_out), 8'h00);

`ifdef MOD_PHASE_OFFSET_EN
        phase_write(2'd0, 8'd0);
        phase_write(2'd1, 8'd1);
        phase_write(2'd2, 8'd2);
        pulse_resync();
        check("ph_resync", 8'(mod_out), 8'h07);
        ticks(1); check("ph_t1", 8'(mod_out), 8'h03);
        ticks(1); check("ph_t2", 8'(mod_out), 8'h01);
        ticks(1); check("ph_t3", 8'(mod_out), 8'h00);
        phase_write(2'd0, 8'd5);
        pulse_resync();
        ticks(2); check("ph_clamp_t2", 8'(mod_out[0]), 8'h01);
        ticks(1); check("ph_clamp_t3", 8'(mod_out[0]), 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multichannel_modulation.md
Name: multichannel_modulation

Overview:
- Generalised successor to the single-channel square-wave modulator in the transducer drive path.
- Generates NUM_CH independent square-wave modulation envelopes, each counted in rising edges of the shared carrier `sync` input.
- Per-channel half-period is runtime-programmable through a shadow register. Updates commit glitch-free at full-period boundaries.
- A global resync realigns all channels. Outputs feed the per-transducer drive gating.

Parameters:
- NUM_CH, 4, number of modulation channels (1..64).
- PERIOD_W, 8, width of half-period counters and config field.
- HALF_PERIOD_RST, 3, half-period (in sync ticks) loaded into every channel at reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sync  in  1  carrier reference; each rising edge is one tick.
- mod_enable  in  NUM_CH  per-channel count enable.
- resync  in  1  synchronous pulse; realigns all channels.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_half_period  in  PERIOD_W  new half-period, in ticks.
- mod_out  out  NUM_CH  modulation envelope per channel.
- period_start  out  NUM_CH  one-cycle pulse when that channel's mod_out rises.

Behaviour:
- Reset (async, rst_n=0):
  - mod_out = all 1; period_start = 0; counters = 0.
  - Active and shadow half-period = HALF_PERIOD_RST; pending = 0.
  - sync edge register = 0.
- Tick detection:
  - sync_q <= sync every clk.
  - tick = sync & ~sync_q. A rising edge sampled at edge n is acted on at edge n.
- Per channel, priority order:
  1. resync
  2. hp==0
  3. tick with enable
  4. hold
- Resync:
  - cnt <= 0; mod_out <= 1.
  - If pending, commit the shadow to active and clear pending.
  - period_start is not pulsed.
- hp==0 (active half-period 0): mod_out forced 1, cnt held 0, no pulses.
- Tick with mod_enable[ch]=1:
  - If cnt == hp-1: cnt <= 0 and mod_out toggles. Otherwise cnt <= cnt+1.
  - On a 0->1 toggle (full-period boundary): period_start pulses the next cycle. If pending, commit the shadow to active and clear pending.
- Enable low: cnt and mod_out hold, so output is frozen at its current level.
- Write, cfg_we=1, cfg_ch<NUM_CH, channel enabled: shadow <= value; pending <= 1.
- Write, cfg_ch>=NUM_CH: ignored.
- Write while mod_enable[ch]=0 or active hp==0: applied immediately to active; cnt <= 0; mod_out <= 1; pending <= 0.
- Write in the same cycle as a commit: the commit uses the pre-write shadow; the new value lands in shadow with pending=1.
- Write in the same cycle as resync: resync commits the old shadow; the new write sets shadow and pending.
- Latency: mod_out changes on the clk edge that samples the sync rise.
- Arithmetic: counters are unsigned PERIOD_W; the hp-1 compare never wraps because hp==0 is handled first.
- Reset mid-operation: immediate return to reset values; pending writes are lost.

Optional Feature:
- Macro: MOD_PHASE_OFFSET_EN.
- With macro defined:
  - Adds ports cfg_phase_we (in, 1) and cfg_phase (in, PERIOD_W), addressed by cfg_ch.
  - Adds a per-channel offset register, reset to 0.
  - On resync, cnt <= offset if offset < new active hp, else 0.
  - This staggers the first toggle per channel for beam steering.
- Without macro: no ports or registers; resync always loads cnt <= 0.

Decomposition:
- Package modulation_pkg:
  - PERIOD_W default constant.
  - half_period_t typedef (logic [PERIOD_W-1:0]).
  - channel-state struct: cnt, active, shadow, pending, out.
- Sub-module mod_channel: one channel's counter, shadow/commit logic and output.
- Top: sync edge detect, config address decode, generate loop of NUM_CH mod_channel instances.

Test Plan:
- Reset, all enabled, sync every 4 clk, hp=3 -> mod_out=1 through the first 2 ticks; falls on the 3rd tick (~12 clk); rises on the 6th; period_start pulses once per 24 clk.
- Write hp=6 to ch1 mid-high-phase -> ch1 keeps hp=3 until its next 0->1 edge, then toggles every 6 ticks; ch0 unaffected.
- Drop mod_enable[2] while mod_out[2]=0 for 5 ticks -> held 0; re-enable -> resumes the count where it stopped.
- Assert resync with ch0 at cnt=2, low, pending=1 -> all mod_out=1, cnt=0, new hp active, no period_start pulse.
- Write hp=0 to a disabled channel, then enable -> mod_out stays 1 and no pulses; a write to cfg_ch=NUM_CH changes nothing.
- With MOD_PHASE_OFFSET_EN: set offsets 0,1,2 on ch0-2 with hp=3, then resync -> first falls on ticks 3,2,1 respectively; offset 5 clamps to 0.
